// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: walks each instruction through fetch/decode/execute/memory/writeback
// over a shared memory port, stalls on mem_ready and counts retired instructions.
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             bne,
  output logic             ior_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             zero_ext,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_count
);

  // state  | meaning
  // FETCH  | read instruction at PC, PC <= PC+4 when memory ready
  // DECODE | branch target into ALUOut, dispatch on opcode
  // MEMADR | lw/sw effective address
  // MEMRD  | data read, wait for mem_ready
  // MEMWB  | write loaded data to rt
  // MEMWR  | data write, wait for mem_ready
  // EXEC   | R-type ALU operation
  // RWB    | write ALU result to rd
  // BRANCH | beq/bne compare and conditional PC load
  // JUMP   | j
  // IEXEC  | immediate ALU operation
  // IWB    | write immediate result to rt
  // JAL    | jump and link $31
  // JR     | jump to rs
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_t state, state_nxt;
  logic   retire;
  logic   imm_logical;

  assign imm_logical = (opcode == OP_ANDI) || (opcode == OP_ORI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instr_count <= '0;
    else if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_nxt     = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    bne           = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 4'b0000;
    zero_ext      = 1'b0;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    retire        = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_nxt = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:                      state_nxt = S_MEMADR;
          OP_RTYPE:                          state_nxt = (funct == FN_JR) ? S_JR : S_EXEC;
          OP_BEQ, OP_BNE:                    state_nxt = S_BRANCH;
          OP_J:                              state_nxt = S_JUMP;
          OP_JAL:                            state_nxt = S_JAL;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_nxt = S_IEXEC;
          default: begin
            illegal_op = 1'b1;
            state_nxt  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read  = 1'b1;
        ior_d     = 1'b1;
        state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        ior_d     = 1'b1;
        state_nxt = mem_ready ? S_FETCH : S_MEMWR;
        retire    = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 4'b0010;
        state_nxt = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 4'b0001;
        pc_source     = 2'b01;
        pc_write_cond = (opcode == OP_BEQ);
        bne           = (opcode == OP_BNE);
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        retire     = 1'b1;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
        retire    = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        zero_ext  = imm_logical;
        case (opcode)
          OP_SLTI: alu_op = 4'b0101;
          OP_ANDI: alu_op = 4'b0011;
          OP_ORI:  alu_op = 4'b0100;
          default: alu_op = 4'b0000;
        endcase
        state_nxt = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        zero_ext  = imm_logical;
        retire    = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase

    // Reset gates every output immediately, so an in-flight write is cut off mid-cycle.
    if (!reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      bne           = 1'b0;
      ior_d         = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 2'b00;
      mem_to_reg    = 2'b00;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 4'b0000;
      zero_ext      = 1'b0;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
      retire        = 1'b0;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction plans of expected step sequences, driven with random
// stall lengths and opcodes, checked every cycle against a spec-level output table.
module tb_mc_control_fsm;
  localparam int CW = 4;
  localparam int VW = 27 + CW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic          mem_ready = 1'b0;
  logic          pc_write, pc_write_cond, bne, ior_d, mem_read, mem_write, ir_write;
  logic [1:0]    reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic          reg_write, alu_src_a, zero_ext, illegal_op;
  logic [3:0]    alu_op, state_dbg;
  logic [CW-1:0] instr_count;

  mc_control_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .bne(bne), .ior_d(ior_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .zero_ext(zero_ext), .pc_source(pc_source),
    .illegal_op(illegal_op), .state_dbg(state_dbg), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   st;
    logic rdy;
  } step_t;

  step_t         plan[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [CW-1:0] model_cnt = '0;
  logic [VW-1:0] exp_v;
  logic          exp_valid = 1'b0;
  int            mw_cycles, fetch_cycles, rw_cycles, ill_cycles;

  function automatic logic [VW-1:0] dut_vec();
    return {pc_write, pc_write_cond, bne, ior_d, mem_read, mem_write, ir_write, reg_dst,
            mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, zero_ext, pc_source,
            illegal_op, state_dbg, instr_count};
  endfunction

  function automatic logic is_legal(logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                      6'h23, 6'h2B};
  endfunction

  // Output table written from the control-signal description of each step.
  function automatic logic [VW-1:0] expect_vec(int st, logic [5:0] op, logic rdy,
                                               logic [CW-1:0] cnt);
    logic pw = 0, pwc = 0, bn = 0, iod = 0, mr = 0, mw = 0, irw = 0, rw = 0, asa = 0;
    logic ze = 0, ill = 0;
    logic [1:0] rd = 0, m2r = 0, asb = 0, ps = 0;
    logic [3:0] aop = 0;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1:  begin asb = 2'b11; ill = !is_legal(op); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; aop = 4'b0010; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; aop = 4'b0001; ps = 2'b01; pwc = (op == 6'h04); bn = (op == 6'h05); end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin
            asa = 1; asb = 2'b10;
            aop = (op == 6'h0A) ? 4'b0101 : (op == 6'h0C) ? 4'b0011 :
                  (op == 6'h0D) ? 4'b0100 : 4'b0000;
            ze = (op == 6'h0C) || (op == 6'h0D);
          end
      11: begin rw = 1; ze = (op == 6'h0C) || (op == 6'h0D); end
      12: begin pw = 1; ps = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
      13: begin pw = 1; ps = 2'b11; end
      default: ;
    endcase
    return {pw, pwc, bn, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, ze, ps, ill, 4'(st), cnt};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("cycle_outputs", 32'(dut_vec()), 32'(exp_v));
      if (mem_write) mw_cycles++;
      if (reg_write) rw_cycles++;
      if (illegal_op) ill_cycles++;
      if (state_dbg == 4'd0) fetch_cycles++;
    end
  end

  task automatic add_step(int st, logic rdy);
    step_t s;
    s.st = st;
    s.rdy = rdy;
    plan.push_back(s);
  endtask

  // Builds the step list of one instruction, then replays it cycle by cycle.
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, int fw, int mw);
    plan.delete();
    for (int i = 0; i < fw; i++) add_step(0, 1'b0);
    add_step(0, 1'b1);
    add_step(1, 1'($urandom));
    if (op == 6'h23) begin
      add_step(2, 1'($urandom));
      for (int i = 0; i < mw; i++) add_step(3, 1'b0);
      add_step(3, 1'b1);
      add_step(4, 1'($urandom));
    end else if (op == 6'h2B) begin
      add_step(2, 1'($urandom));
      for (int i = 0; i < mw; i++) add_step(5, 1'b0);
      add_step(5, 1'b1);
    end else if (op == 6'h00 && fn == 6'h08) add_step(13, 1'($urandom));
    else if (op == 6'h00) begin add_step(6, 1'($urandom)); add_step(7, 1'($urandom)); end
    else if (op == 6'h04 || op == 6'h05) add_step(8, 1'($urandom));
    else if (op == 6'h02) add_step(9, 1'($urandom));
    else if (op == 6'h03) add_step(12, 1'($urandom));
    else if (is_legal(op)) begin add_step(10, 1'($urandom)); add_step(11, 1'($urandom)); end

    opcode = op;
    funct = fn;
    mw_cycles = 0; fetch_cycles = 0; rw_cycles = 0; ill_cycles = 0;
    foreach (plan[i]) begin
      mem_ready = plan[i].rdy;
      exp_v = expect_vec(plan[i].st, op, plan[i].rdy, model_cnt);
      exp_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    if (is_legal(op)) model_cnt = model_cnt + 1'b1;
  endtask

  logic [5:0] op_tab[13] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03,
                             6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h3F};
  logic [5:0] bad_tab[4] = '{6'h3F, 6'h01, 6'h06, 6'h20};

  initial begin
    reset = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'h2B;
    #12;
    chk("reset_outputs", 32'(dut_vec()), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_held", 32'(dut_vec()), 32'd0);
    reset = 1'b1;

    // add: 0,1,6,7,0 with one retirement
    run_instr(6'h00, 6'h20, 0, 0);
    mem_ready = 1'b0;
    exp_v = expect_vec(0, 6'h00, 1'b0, model_cnt);
    #2;
    chk("add_count", 32'(instr_count), 32'd1);

    // lw: fetch held 4 cycles, MEMRD 3 cycles
    run_instr(6'h23, 6'h00, 3, 2);
    chk("lw_fetch_cycles", fetch_cycles, 4);

    // sw: mem_write exactly 3 cycles, no register write
    run_instr(6'h2B, 6'h00, 0, 2);
    chk("sw_write_cycles", mw_cycles, 3);
    chk("sw_no_regwrite", rw_cycles, 0);

    run_instr(6'h04, 6'h00, 0, 0);
    run_instr(6'h05, 6'h00, 0, 0);
    run_instr(6'h03, 6'h00, 0, 0);
    run_instr(6'h3F, 6'h00, 0, 0);
    chk("illegal_pulse", ill_cycles, 1);
    mem_ready = 1'b0;
    exp_v = expect_vec(0, 6'h3F, 1'b0, model_cnt);
    #2;
    chk("illegal_no_count", 32'(instr_count), 32'd6);

    for (int n = 0; n < 300; n++) begin
      int k;
      logic [5:0] op, fn;
      k = $urandom_range(0, 12);
      op = (k == 12) ? bad_tab[$urandom_range(0, 3)] : op_tab[k];
      fn = 6'($urandom);
      if (k == 0 && fn == 6'h08) fn = 6'h20;
      if (k == 1) fn = 6'h08;
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // reset while a store is stalled
    plan.delete();
    opcode = 6'h2B;
    funct = 6'h00;
    add_step(0, 1'b1);
    add_step(1, 1'b0);
    add_step(2, 1'b0);
    add_step(5, 1'b0);
    foreach (plan[i]) begin
      mem_ready = plan[i].rdy;
      exp_v = expect_vec(plan[i].st, 6'h2B, plan[i].rdy, model_cnt);
      exp_valid = 1'b1;
      if (i == 3) begin
        @(negedge clk);
        #2;
        chk("memwr_active", 32'(mem_write), 32'd1);
        exp_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(dut_vec()), 32'd0);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    chk("reset_after_edge", 32'(dut_vec()), 32'd0);
    reset = 1'b1;
    model_cnt = '0;
    run_instr(6'h08, 6'h00, 1, 0);
    run_instr(6'h02, 6'h00, 0, 0);
    exp_valid = 1'b0;
    #2;
    chk("final_count", 32'(instr_count), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
